action_scheduler: RTL

ACTION_SCHEDULER -- requirements
Module: action_scheduler

---
 rtl/action_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/action_scheduler.sv
// Arbitrates gravity ticks and button pulses into a single valid/ready action stream,
// with a halt/restart path driven by the game-over level.
module action_scheduler #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       btn_down_en,
  input  logic       btn_rotate_en,
  input  logic       btn_left_en,
  input  logic       btn_right_en,
  input  logic       game_over,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic [4:0] pending,
  output logic       halted,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  // Handshake: an action transfers on any rising edge where act_valid & act_ready;
  // once raised, act_valid and act_code hold steady until that transfer or a timeout drop.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HALT    = 2'd2,
    S_RESTART = 2'd3
  } state_t;

  localparam logic [2:0] CODE_NONE    = 3'b000;
  localparam logic [2:0] CODE_GRAVITY = 3'b001;
  localparam logic [2:0] CODE_DOWN    = 3'b010;
  localparam logic [2:0] CODE_ROTATE  = 3'b011;
  localparam logic [2:0] CODE_LEFT    = 3'b100;
  localparam logic [2:0] CODE_RIGHT   = 3'b101;
  localparam logic [2:0] CODE_RESTART = 3'b110;

  // Wait counter value on the last cycle an action may stay presented.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [4:0] served_mask;

  logic [4:0] pulses;
  logic       any_btn;
  logic [4:0] cand;
  logic       sel_any;
  logic [4:0] sel_mask;
  logic [2:0] sel_code;
  logic       handshake;
  logic       expire;

  assign pulses    = {tick_en, btn_down_en, btn_rotate_en, btn_left_en, btn_right_en};
  assign any_btn   = |pulses[3:0];
  assign handshake = act_valid & act_ready;
  assign expire    = (wait_cnt == LAST_WAIT);
  assign state_dbg = state;

  // Opposing left/right requests cancel each other before priority selection.
  always_comb begin
    cand = pending;
    if (pending[1] && pending[0]) begin
      cand[1:0] = 2'b00;
    end
  end

  always_comb begin
    sel_any  = 1'b1;
    sel_mask = 5'b00000;
    sel_code = CODE_NONE;
    if (cand[4]) begin
      sel_mask = 5'b10000;
      sel_code = CODE_GRAVITY;
    end else if (cand[3]) begin
      sel_mask = 5'b01000;
      sel_code = CODE_DOWN;
    end else if (cand[2]) begin
      sel_mask = 5'b00100;
      sel_code = CODE_ROTATE;
    end else if (cand[1]) begin
      sel_mask = 5'b00010;
      sel_code = CODE_LEFT;
    end else if (cand[0]) begin
      sel_mask = 5'b00001;
      sel_code = CODE_RIGHT;
    end else begin
      sel_any = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= 5'b00000;
      act_valid   <= 1'b0;
      act_code    <= CODE_NONE;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= 8'd0;
      served_mask <= 5'b00000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (game_over) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            pending   <= 5'b00000;
            act_valid <= 1'b0;
            act_code  <= CODE_NONE;
          end else begin
            // New pulses are merged after selection, so they never steer this cycle's pick.
            pending <= cand | pulses;
            if (sel_any) begin
              state       <= S_ISSUE;
              act_valid   <= 1'b1;
              act_code    <= sel_code;
              served_mask <= sel_mask;
              wait_cnt    <= 8'd0;
            end else begin
              act_valid <= 1'b0;
              act_code  <= CODE_NONE;
            end
          end
        end

        S_ISSUE: begin
          if (handshake || expire) begin
            // A fresh pulse from the served source outranks its clear.
            pending   <= (pending & ~served_mask) | pulses;
            state     <= S_IDLE;
            act_valid <= 1'b0;
            act_code  <= CODE_NONE;
            if (!handshake) begin
              timeout_err <= 1'b1;
            end
          end else begin
            pending  <= pending | pulses;
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_HALT: begin
          pending <= 5'b00000;
          if (any_btn) begin
            state     <= S_RESTART;
            halted    <= 1'b0;
            act_valid <= 1'b1;
            act_code  <= CODE_RESTART;
            wait_cnt  <= 8'd0;
          end
        end

        S_RESTART: begin
          if (handshake) begin
            pending   <= pending | pulses;
            state     <= S_IDLE;
            act_valid <= 1'b0;
            act_code  <= CODE_NONE;
          end else if (expire) begin
            pending     <= 5'b00000;
            state       <= S_HALT;
            halted      <= 1'b1;
            timeout_err <= 1'b1;
            act_valid   <= 1'b0;
            act_code    <= CODE_NONE;
          end else begin
            pending  <= pending | pulses;
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          act_valid <= 1'b0;
          act_code  <= CODE_NONE;
        end
      endcase
    end
  end

endmodule
